ub_feeder: RTL and testbench

Read-side sequencer for the unified buffer. On a start command it reads a tile of activations from the buffer one entry per cycle through the buffer's combinational read port and assembles each group of SIZE consecutive entries into a row. It then launches each row into the systolic array's activation inputs with a diagonal skew, so lane i trails lane 0 by i cycles. The block sits between the unified buffer read port and the array's left-edge activation inputs, and reports completion with a one-cycle Done pulse.

---
 rtl/ub_feeder.sv | 157 +++++++++++++++
 tb/tb_ub_feeder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ub_feeder.sv
// Unified-buffer read sequencer: fetches a tile one entry per cycle, packs SIZE entries
// per row and launches each row into the array's activation lanes with a diagonal skew.
module ub_feeder #(
    parameter int unsigned SIZE             = 8,
    parameter int unsigned ACTIVATION_WIDTH = 7,
    parameter int unsigned ADDR_WIDTH       = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             Start,
    input  logic [ADDR_WIDTH-1:0]            Base_Addr,
    input  logic [3:0]                       Num_Rows,
    output logic [ADDR_WIDTH-1:0]            Rd_Addr,
    output logic                             Rd_En,
    input  logic [ACTIVATION_WIDTH-1:0]      Rd_Data,
    output logic [SIZE*ACTIVATION_WIDTH-1:0] Act_Out,
    output logic [SIZE-1:0]                  Act_Valid,
    output logic                             Busy,
    output logic                             Done
);

    localparam int unsigned AW = ACTIVATION_WIDTH;
    localparam int unsigned SW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            rows_q, rows_d;
    logic [3:0]            row_cnt_q, row_cnt_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [AW-1:0]         row_buf_q [SIZE-1];

    logic load;
    logic last_read;
    logic slot_wrap;

    // The last slot of each row is never stored: it goes straight from Rd_Data into the lanes.
    assign slot_wrap = (slot_q == SW'(SIZE - 1));
    assign load      = (state_q == StFetch) && slot_wrap;
    assign last_read = load && (row_cnt_q == rows_q - 4'd1);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        slot_d    = slot_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    if (Num_Rows != 4'd0) begin
                        state_d   = StFetch;
                        addr_d    = Base_Addr;
                        rows_d    = (Num_Rows > 4'(SIZE)) ? 4'(SIZE) : Num_Rows;
                        row_cnt_d = '0;
                        slot_d    = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFetch: begin
                slot_d = slot_wrap ? '0 : slot_q + SW'(1);
                if (load) begin
                    row_cnt_d = row_cnt_q + 4'd1;
                end
                // Rd_Addr freezes on the final read address for the rest of the command.
                if (last_read) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            StDrain: begin
                // slot_q has wrapped to 0 on entry and doubles as the drain counter.
                slot_d = slot_wrap ? '0 : slot_q + SW'(1);
                if (slot_wrap) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rows_q    <= '0;
            row_cnt_q <= '0;
            slot_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            slot_q    <= slot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StFetch) begin
            for (int s = 0; s < int'(SIZE) - 1; s++) begin
                if (slot_q == SW'(s)) begin
                    row_buf_q[s] <= Rd_Data;
                end
            end
        end
    end

    assign Rd_Addr = addr_q;
    assign Rd_En   = (state_q == StFetch);
    assign Busy    = (state_q != StIdle);
    assign Done    = (state_q == StDone);

    for (genvar i = 0; i < int'(SIZE); i++) begin : g_lane
        logic [AW-1:0] dat_q [i+1];
        logic [i:0]    vld_q;
        logic [AW-1:0] row_val;

        if (i == int'(SIZE) - 1) begin : g_direct
            assign row_val = Rd_Data;
        end else begin : g_buf
            assign row_val = row_buf_q[i];
        end

        // Lane i is an (i+1)-deep chain, giving the i-cycle skew relative to lane 0.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int j = 0; j <= i; j++) begin
                    dat_q[j] <= '0;
                end
            end else begin
                vld_q[0] <= load;
                dat_q[0] <= load ? row_val : '0;
                for (int j = 1; j <= i; j++) begin
                    vld_q[j] <= vld_q[j-1];
                    dat_q[j] <= dat_q[j-1];
                end
            end
        end

        assign Act_Valid[i]        = vld_q[i];
        assign Act_Out[i*AW +: AW] = vld_q[i] ? dat_q[i] : '0;
    end

endmodule

// File: tb/tb_ub_feeder.sv
// Directed bench for ub_feeder: a command table checked cycle by cycle against a timing model,
// plus hand-written reset sequences.
module tb_ub_feeder;

    localparam int SIZE = 8;
    localparam int AW   = 7;
    localparam int ADW  = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 Start;
    logic [ADW-1:0]       Base_Addr;
    logic [3:0]           Num_Rows;
    logic [ADW-1:0]       Rd_Addr;
    logic                 Rd_En;
    logic [AW-1:0]        Rd_Data;
    logic [SIZE*AW-1:0]   Act_Out;
    logic [SIZE-1:0]      Act_Valid;
    logic                 Busy;
    logic                 Done;

    logic [AW-1:0] mem [64];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign Rd_Data = mem[Rd_Addr];

    ub_feeder #(
        .SIZE            (SIZE),
        .ACTIVATION_WIDTH(AW),
        .ADDR_WIDTH      (ADW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .Base_Addr(Base_Addr),
        .Num_Rows (Num_Rows),
        .Rd_Addr  (Rd_Addr),
        .Rd_En    (Rd_En),
        .Rd_Data  (Rd_Data),
        .Act_Out  (Act_Out),
        .Act_Valid(Act_Valid),
        .Busy     (Busy),
        .Done     (Done)
    );

    typedef struct {
        int base;
        int nrows;
        int ss_cycle;   // cycle of a second Start (0 = none)
        int ss_base;
        int exp_reads;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic chk_quiet(input int c, input int exp_addr);
        chk("q_rd_en", c, 64'(Rd_En), 64'd0);
        chk("q_rd_addr", c, 64'(Rd_Addr), 64'(exp_addr));
        chk("q_act_valid", c, 64'(Act_Valid), 64'd0);
        chk("q_act_out", c, 64'(Act_Out), 64'd0);
        chk("q_busy", c, 64'(Busy), 64'd0);
        chk("q_done", c, 64'(Done), 64'd0);
    endtask

    // Drives one command starting at the next negedge and checks every cycle through Done+2.
    task automatic run_cmd(input vec_t v);
        int n;
        int d;
        int reads;
        int dones;
        int dcyc;
        int rel;
        int ev;
        int eval;
        n     = (v.nrows > SIZE) ? SIZE : v.nrows;
        d     = (n == 0) ? 1 : n * SIZE + SIZE + 1;
        reads = 0;
        dones = 0;
        dcyc  = -1;
        @(negedge clk);
        Start     = 1'b1;
        Base_Addr = ADW'(v.base);
        Num_Rows  = 4'(v.nrows);
        @(posedge clk);
        for (int c = 1; c <= d + 2; c++) begin
            @(negedge clk);
            Start     = (c == v.ss_cycle);
            Base_Addr = ADW'((c == v.ss_cycle) ? v.ss_base : v.base);
            chk("rd_en", c, 64'(Rd_En), 64'(c <= n * SIZE));
            if (c <= n * SIZE) begin
                chk("rd_addr", c, 64'(Rd_Addr), 64'((v.base + c - 1) % 64));
            end else if (n > 0) begin
                chk("rd_addr_hold", c, 64'(Rd_Addr), 64'((v.base + n * SIZE - 1) % 64));
            end
            for (int i = 0; i < SIZE; i++) begin
                rel  = c - (SIZE + 1) - i;
                ev   = (rel >= 0 && rel % SIZE == 0 && rel / SIZE < n) ? 1 : 0;
                eval = ev ? (v.base + rel + i) % 64 : 0;
                chk("act_valid", c, 64'(Act_Valid[i]), 64'(ev));
                chk("act_out", c, 64'(Act_Out[i*AW +: AW]), 64'(eval));
            end
            chk("busy", c, 64'(Busy), 64'(c <= d));
            chk("done", c, 64'(Done), 64'(c == d));
            if (Rd_En) reads++;
            if (Done) begin
                dones++;
                if (dcyc < 0) dcyc = c;
            end
        end
        chk("n_reads", 0, 64'(reads), 64'(v.exp_reads));
        chk("done_cycle", 0, 64'(dcyc), 64'(v.exp_done));
        chk("n_done", 0, 64'(dones), 64'd1);
    endtask

    vec_t vecs [6];

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = AW'(a);
        vecs[0] = '{base: 0,  nrows: 8,  ss_cycle: 0,  ss_base: 0,  exp_reads: 64, exp_done: 73};
        vecs[1] = '{base: 60, nrows: 1,  ss_cycle: 0,  ss_base: 0,  exp_reads: 8,  exp_done: 17};
        vecs[2] = '{base: 0,  nrows: 0,  ss_cycle: 0,  ss_base: 0,  exp_reads: 0,  exp_done: 1};
        vecs[3] = '{base: 0,  nrows: 12, ss_cycle: 0,  ss_base: 0,  exp_reads: 64, exp_done: 73};
        vecs[4] = '{base: 0,  nrows: 8,  ss_cycle: 20, ss_base: 33, exp_reads: 64, exp_done: 73};
        vecs[5] = '{base: 5,  nrows: 3,  ss_cycle: 0,  ss_base: 0,  exp_reads: 24, exp_done: 33};

        rst_n     = 1'b0;
        Start     = 1'b0;
        Base_Addr = '0;
        Num_Rows  = '0;
        repeat (3) @(negedge clk);
        chk_quiet(0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet(0, 0);

        for (int t = 0; t < 6; t++) run_cmd(vecs[t]);

        // Abort a full tile with reset during cycle 30.
        @(negedge clk);
        Start     = 1'b1;
        Base_Addr = '0;
        Num_Rows  = 4'd8;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            Start = 1'b0;
            chk("pre_rst_addr", c, 64'(Rd_Addr), 64'(c - 1));
            if (c == 30) rst_n = 1'b0;
        end
        for (int c = 31; c <= 50; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            chk_quiet(c, 0);
        end
        run_cmd(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
